// File: rtl/input_buffer_arbiter_pkg.sv
// Shared types and helpers for the input buffer arbiter and its stream FIFO.
package input_buffer_pkg;

  localparam int DATA_W = 16;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ACCUM = 2'd0,  // filling the frame from the stream FIFO or host writes
    HRD   = 2'd1,  // second cycle of a host read, data returned from buffer
    DRAIN = 2'd2   // buffer streaming the frame to the core, writes blocked
  } state_t;

  // Ceiling log2, minimum result 1 so a width derived from it is never zero.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result = result + 1;
        rem    = rem >> 1;
      end
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/input_buffer_arbiter_stream_fifo.sv
// Small synchronous skid FIFO for front-end stream samples. The head entry
// is read straight out of the storage registers and is valid whenever empty=0.
// A push while full is accepted only when a pop happens in the same cycle.
module stream_fifo
  import input_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int PW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sample storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; entries are only read when
    // count says they were written, and leaving reset off keeps it plain RAM.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/input_buffer_arbiter.sv
// Sequences the single-port input buffer: drains stream samples and host
// accesses into it while a frame accumulates, and blocks every write while
// the buffer streams the finished frame to the core.
module input_buffer_arbiter
  import input_buffer_pkg::*;
#(
  parameter int CHANNELS   = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = clog2(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strm_valid,
  input  logic [DATA_W-1:0] strm_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              buf_en,
  output logic [DATA_W-1:0] buf_data_in,
  output logic              buf_ext_en,
  output logic              buf_ext_wren,
  output logic [AW-1:0]     buf_ext_addr,
  output logic [DATA_W-1:0] buf_ext_din,
  output logic              buf_enb,
  input  logic [DATA_W-1:0] buf_ext_dout,
  input  logic              buf_valid,
  output logic              frame_done,
  output logic [AW:0]       fill_cnt,
  output logic [7:0]        drop_cnt
);

  state_t            state_q;
  state_t            state_d;
  logic              seen_valid;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_load;
  logic              frame_wr;
  logic              frame_last;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              drop;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (strm_valid),
    .pop   (fifo_pop),
    .din   (strm_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_data)
  );

  // A write that fills the last channel closes the frame.
  assign frame_last = (fill_cnt == (AW+1)'(CHANNELS - 1));
  assign drop       = strm_valid && fifo_full && !fifo_pop;

  // Read data is passed through during the ack cycle, then held.
  assign host_rdata = (!rst && state_q == HRD) ? buf_ext_dout : rdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next state and buffer/host strobes; all strobes held low during reset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    fifo_pop     = 1'b0;
    frame_wr     = 1'b0;
    rdata_load   = 1'b0;
    buf_en       = 1'b0;
    buf_data_in  = '0;
    buf_ext_en   = 1'b0;
    buf_ext_wren = 1'b0;
    buf_ext_addr = '0;
    buf_ext_din  = '0;
    buf_enb      = 1'b0;
    host_ack     = 1'b0;
    frame_done   = 1'b0;
    if (!rst) begin
      case (state_q)
        ACCUM: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            buf_en      = 1'b1;
            buf_data_in = fifo_data;
            frame_wr    = 1'b1;
          end else if (host_req && host_we) begin
            // Host writes advance the buffer pointer like a stream sample.
            buf_ext_wren = 1'b1;
            buf_ext_addr = host_addr;
            buf_ext_din  = host_wdata;
            host_ack     = 1'b1;
            frame_wr     = 1'b1;
          end else if (host_req) begin
            buf_ext_en   = 1'b1;
            buf_enb      = 1'b1;
            buf_ext_addr = host_addr;
            state_d      = HRD;
          end
          if (frame_wr && frame_last) state_d = DRAIN;
        end
        HRD: begin
          buf_ext_en   = 1'b1;
          buf_enb      = 1'b1;
          buf_ext_addr = host_addr;
          host_ack     = 1'b1;
          rdata_load   = 1'b1;
          state_d      = ACCUM;
        end
        DRAIN: begin
          buf_enb = 1'b1;
          if (seen_valid && !buf_valid) begin
            frame_done = 1'b1;
            state_d    = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Readout tracking: wait for buf_valid to rise, then to fall.
  always_ff @(posedge clk) begin
    if (rst)                           seen_valid <= 1'b0;
    else if (frame_done)               seen_valid <= 1'b0;
    else if (state_q == DRAIN && buf_valid) seen_valid <= 1'b1;
  end

  // Frame fill counter, cleared on the write that completes the frame.
  always_ff @(posedge clk) begin
    if (rst)              fill_cnt <= '0;
    else if (frame_wr)    fill_cnt <= frame_last ? '0 : fill_cnt + 1'b1;
  end

  // Saturating count of samples lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
  end

  // Held copy of the last host read result.
  always_ff @(posedge clk) begin
    if (rst)             rdata_q <= '0;
    else if (rdata_load) rdata_q <= buf_ext_dout;
  end

endmodule
